wb_uart_rx: RTL and testbench

Wishbone-slave UART receiver, the receive-side counterpart of the existing SoC UART transmitter. It deserialises 8N1 frames from `uart_rx_i` at a programmable bit period and buffers received bytes in a small FIFO. The CPU drains the FIFO over the shared Wishbone bus through the mux, with an optional level interrupt. It occupies its own address window behind `wb_mux`, alongside `wb_uart`.

---
 rtl/wb_uart_rx.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_wb_uart_rx.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - Wishbone-slave 8N1 UART receiver with receive FIFO
//
// wb_uart_rx_fifo: circular byte buffer behind the receiver.
//   push_i/wdata_i  write one entry (caller guarantees room or a same-cycle pop)
//   pop_i           drop the head entry (caller guarantees not empty)
//   rdata_o         head entry, combinational
//   empty_o/full_o  occupancy flags; count_o entries held
//
// wb_uart_rx: deserialises 8N1 frames from uart_rx_i and exposes them over Wishbone.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   wb_addr_i[3:2]           register select: 0 RXDATA, 1 STATUS, 2 DIVISOR, 3 CTRL
//   wb_data_i, wb_sel_i      write data and byte selects
//   wb_we_i, wb_cyc_i, wb_stb_i  bus cycle qualifiers
//   wb_ack_o, wb_data_o      registered single-cycle ack and read data
//   uart_rx_i                asynchronous serial input, idle high
//   rx_irq_o                 IRQEN and FIFO not empty, registered

module wb_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_i) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign rdata_o = mem[rd_ptr[AW-1:0]];
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_o = wr_ptr - rd_ptr;
endmodule

module wb_uart_rx #(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int DEFAULT_DIVISOR = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     rx_irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    // Input synchroniser; resets to the idle-high level so reset never fakes a start bit.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Registers
    logic [15:0] divisor_q;
    logic        irqen_q;
    logic        overrun_q;
    logic        frameerr_q;
    logic        irq_q;

    // FIFO
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_head;
    logic        fifo_empty;
    logic        fifo_full;
    logic [AW:0] fifo_count;
    logic [3:0]  cnt_field;

    // Receiver
    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] div_l_q, div_l_d;
    logic        push_req;
    logic        fe_set;
    logic        ovr_set;

    // Bus decode: a request is only taken while the previous ack is low, which
    // makes a held strobe ack every other cycle and keeps side effects to one.
    logic        bus_req;
    logic [1:0]  reg_sel;
    logic        rd_req;
    logic        wr_req;
    logic [WB_DATA_WIDTH-1:0] rd_mux;
    logic [15:0] div_merged;
    logic [15:0] div_new;
    logic        clr_ovr;
    logic        clr_fe;

    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_sel = wb_addr_i[3:2];
    assign rd_req  = bus_req & ~wb_we_i;
    assign wr_req  = bus_req & wb_we_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        div_l_d  = div_l_q;
        push_req = 1'b0;
        fe_set   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    div_l_d = divisor_q;
                    cnt_d   = divisor_q >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s) begin
                        // Reload with div_l-1: expiry at zero costs one extra cycle,
                        // so this spaces samples exactly div_l clocks apart.
                        cnt_d   = div_l_q - 16'd1;
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = div_l_q - 16'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            div_l_q <= 16'(DEFAULT_DIVISOR);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            div_l_q <= div_l_d;
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign fifo_pop  = rd_req & (reg_sel == 2'd0) & ~fifo_empty;
    assign fifo_push = push_req & (~fifo_full | fifo_pop);
    assign ovr_set   = push_req & fifo_full & ~fifo_pop;

    wb_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (shift_q),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign cnt_field = (int'(fifo_count) > 15) ? 4'hf : 4'(fifo_count);

    always_comb begin
        rd_mux = '0;
        unique case (reg_sel)
            2'd0: rd_mux = {24'd0, (fifo_empty ? 8'd0 : fifo_head)};
            2'd1: rd_mux = {24'd0, cnt_field, frameerr_q, overrun_q, fifo_full, ~fifo_empty};
            2'd2: rd_mux = {16'd0, divisor_q};
            2'd3: rd_mux = {31'd0, irqen_q};
            default: rd_mux = '0;
        endcase
    end

    assign div_merged = {(wb_sel_i[1] ? wb_data_i[15:8] : divisor_q[15:8]),
                         (wb_sel_i[0] ? wb_data_i[7:0]  : divisor_q[7:0])};
    assign div_new    = (div_merged < 16'd2) ? 16'd2 : div_merged;
    assign clr_ovr    = wr_req & (reg_sel == 2'd1) & wb_sel_i[0] & wb_data_i[2];
    assign clr_fe     = wr_req & (reg_sel == 2'd1) & wb_sel_i[0] & wb_data_i[3];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_ack_o   <= 1'b0;
            wb_data_o  <= '0;
            divisor_q  <= 16'(DEFAULT_DIVISOR);
            irqen_q    <= 1'b0;
            overrun_q  <= 1'b0;
            frameerr_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wb_ack_o  <= bus_req;
            wb_data_o <= rd_req ? rd_mux : '0;
            if (wr_req && reg_sel == 2'd2) begin
                divisor_q <= div_new;
            end
            if (wr_req && reg_sel == 2'd3 && wb_sel_i[0]) begin
                irqen_q <= wb_data_i[0];
            end
            // A hardware set on the same cycle as a software clear wins.
            overrun_q  <= ovr_set | (overrun_q & ~clr_ovr);
            frameerr_q <= fe_set | (frameerr_q & ~clr_fe);
            irq_q      <= irqen_q & ~fifo_empty;
        end
    end

    assign rx_irq_o = irq_q;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{wb_addr_i, wb_data_i, wb_sel_i};
endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - directed scoreboard bench for wb_uart_rx
module tb_wb_uart_rx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        uart_rx = 1'b1;
    logic        irq;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_fe = 1'b0;
    logic [31:0] rd;

    wb_uart_rx #(
        .WB_DATA_WIDTH   (32),
        .WB_ADDR_WIDTH   (32),
        .FIFO_DEPTH      (DEPTH),
        .DEFAULT_DIVISOR (16)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_wdata),
        .wb_sel_i  (wb_sel),
        .wb_we_i   (wb_we),
        .wb_cyc_i  (wb_cyc),
        .wb_stb_i  (wb_stb),
        .wb_ack_o  (wb_ack),
        .wb_data_o (wb_rdata),
        .uart_rx_i (uart_rx),
        .rx_irq_o  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called between clock edges; returns one ns after the ack edge.
    task automatic wb_xfer(input logic we, input logic [1:0] r, input logic [31:0] wdata,
                           input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        got = 1'b0;
        rdata = '0;
        wb_addr = {28'd0, r, 2'b00};
        wb_wdata = wdata;
        wb_sel = sel;
        wb_we = we;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (wb_ack === 1'b1) begin
                got = 1'b1;
                rdata = wb_rdata;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $error("FAIL wb_ack_timeout observed=0 expected=1");
        end
    endtask

    task automatic wb_write(input logic [1:0] r, input logic [31:0] wdata, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, r, wdata, sel, dummy);
    endtask

    task automatic wb_read(input logic [1:0] r, output logic [31:0] rdata);
        wb_xfer(1'b0, r, '0, 4'hf, rdata);
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        logic [3:0] c;
        n = exp_q.size();
        c = (n > 15) ? 4'hf : 4'(n);
        return {24'd0, c, exp_fe, exp_ovr, (n == DEPTH), (n != 0)};
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] v;
        wb_read(2'd1, v);
        check(tag, v, exp_status());
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] v;
        logic [7:0] e;
        wb_read(2'd0, v);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'd0;
        check(tag, v, {24'd0, e});
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    // Drives one 8N1 frame, d clocks per bit; a low stop bit is left on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int d);
        uart_rx = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (d) @(posedge clk);
            #1;
        end
        uart_rx = stop;
        repeat (d) @(posedge clk);
        #1;
    endtask

    task automatic send_expect(input logic [7:0] b, input int d);
        send_frame(b, 1'b1, d);
        model_push(b);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("rst_status");
        wb_read(2'd2, rd);
        check("rst_divisor", rd, 32'd16);
        wb_read(2'd3, rd);
        check("rst_ctrl", rd, 32'd0);

        // Basic receive
        wb_write(2'd2, 32'd8, 4'hf);
        send_expect(8'hA5, 8);
        check_status("basic_status");
        check("basic_irq_off", {31'd0, irq}, 32'd0);
        check_rx("basic_rx");
        check_status("basic_status_empty");

        // Back-to-back frames fill the FIFO, fifth one overruns
        wb_write(2'd3, 32'd1, 4'hf);
        wb_read(2'd3, rd);
        check("ctrl_rb", rd, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 8);
            model_push(8'(i));
        end
        repeat (2) @(posedge clk);
        #1;
        check("b2b_irq", {31'd0, irq}, 32'd1);
        check_status("b2b_full");
        send_expect(8'h05, 8);
        check_status("b2b_overrun");
        for (int i = 0; i < 3; i++) check_rx("b2b_rx");
        wb_read(2'd0, rd);
        check("b2b_rx_last", rd, {24'd0, exp_q.pop_front()});
        check("irq_during_ack", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        check("irq_after_ack", {31'd0, irq}, 32'd0);
        check_rx("empty_read");
        wb_write(2'd1, 32'h4, 4'h1);
        exp_ovr = 1'b0;
        check_status("ovr_clear");

        // Framing error followed by a long break: one error event only
        send_frame(8'h00, 1'b0, 8);
        exp_fe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_status("fe_set");
        wb_write(2'd1, 32'h8, 4'h1);
        exp_fe = 1'b0;
        check_status("fe_clear");
        repeat (25 * 8) @(posedge clk);
        #1;
        check_status("fe_break_hold");
        uart_rx = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check_status("fe_after_break");

        // Glitch rejection
        wb_write(2'd2, 32'd16, 4'hf);
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_status("glitch_status");
        send_expect(8'h3C, 16);
        check_rx("glitch_then_rx");

        // Divisor change mid-frame takes effect at the next start bit
        fork
            send_frame(8'h5A, 1'b1, 16);
            begin
                repeat (40) @(posedge clk);
                #1;
                wb_write(2'd2, 32'd12, 4'hf);
            end
        join
        model_push(8'h5A);
        wb_read(2'd2, rd);
        check("div_new_rb", rd, 32'd12);
        send_expect(8'hC3, 12);
        check_rx("div_old_rate_rx");
        check_rx("div_new_rate_rx");
        wb_write(2'd2, 32'd0, 4'hf);
        wb_read(2'd2, rd);
        check("div_clamp", rd, 32'd2);
        wb_write(2'd2, 32'h1234, 4'hf);
        wb_write(2'd2, 32'hFF00, 4'h1);
        wb_read(2'd2, rd);
        check("div_bytesel", rd, 32'h1200);
        wb_write(2'd2, 32'd8, 4'hf);

        // Pop acked on the same edge as a push into a full FIFO
        for (int i = 0; i < 4; i++) send_expect(8'h11 + 8'(i), 8);
        check_status("sim_full");
        fork
            send_frame(8'h15, 1'b1, 8);
            begin
                repeat (79) @(posedge clk);
                #1;
                check_rx("sim_pop_rx");
            end
        join
        model_push(8'h15);
        repeat (2) @(posedge clk);
        #1;
        check_status("sim_no_overrun");
        for (int i = 0; i < 4; i++) check_rx("sim_drain_rx");

        // Reset mid-DATA clears every output at once
        send_expect(8'h77, 8);
        check("pre_rst_irq_on", {31'd0, irq}, 32'd1);
        fork
            send_frame(8'hF0, 1'b1, 8);
            begin
                repeat (25) @(posedge clk);
                #1;
                wb_read(2'd0, rd);
                check("pre_rst_rx", rd, {24'd0, exp_q.pop_front()});
                check("pre_rst_ack", {31'd0, wb_ack}, 32'd1);
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_ack", {31'd0, wb_ack}, 32'd0);
                check("async_rst_data", wb_rdata, 32'd0);
                check("async_rst_irq", {31'd0, irq}, 32'd0);
                exp_q.delete();
                exp_ovr = 1'b0;
                exp_fe = 1'b0;
                repeat (24) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check_status("post_rst_status");
        wb_read(2'd2, rd);
        check("post_rst_divisor", rd, 32'd16);
        wb_read(2'd3, rd);
        check("post_rst_ctrl", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
